// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the arb_mux block and its round-robin arbiter.
//   - MODE_FIXED / MODE_RR : values of the arb_mux 'mode' input
//   - clog2_min1()         : index width helper that never returns 0, so a
//                            2-input mux still gets a 1-bit select
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin grant selection. Returns the lowest
//   channel index >= i_ptr whose valid bit is set, wrapping to 0..i_ptr-1.
//
//   Ports
//     i_valid     [NUM_IN-1:0]  per-channel request
//     i_ptr       [SEL_W-1:0]   highest-priority channel this cycle
//     o_grant     [SEL_W-1:0]   granted channel (0 when nothing is valid)
//     o_any_valid               at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_valid,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [SEL_W-1:0]  o_grant,
  output logic              o_any_valid
);

  // Two copies of the request vector side by side: scanning upward from i_ptr
  // over 2*NUM_IN bits visits ptr..N-1 and then wraps to 0..ptr-1 with a plain
  // priority scan, no modular index arithmetic inside the loop condition.
  logic [2*NUM_IN-1:0] w_double;

  assign w_double    = {i_valid, i_valid};
  assign o_any_valid = |i_valid;

  always_comb begin
    logic found;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    o_grant = '0;
    found   = 1'b0;
    for (int j = 0; j < 2*NUM_IN; j++) begin
      if (!found && w_double[j] && (j >= int'(i_ptr))) begin
        found   = 1'b1;
        o_grant = (j >= NUM_IN) ? SEL_W'(j - NUM_IN) : SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
//   N-input, W-bit multiplexer with a single registered output stage and a
//   valid/ready handshake on every input and on the output. The source is
//   either picked by 'sel' (FIXED) or by fair round-robin among requesters (RR).
//
//   Ports
//     clk, rst_n                clock, asynchronous active-low reset
//     mode                      MODE_FIXED (use sel) / MODE_RR (round-robin)
//     sel        [SEL_W-1:0]    channel index used in FIXED mode
//     in_valid   [NUM_IN-1:0]   per-channel data valid
//     in_data    [NUM_IN*WIDTH-1:0]  channel i at [i*WIDTH +: WIDTH]
//     in_ready   [NUM_IN-1:0]   per-channel accept (combinational)
//     out_valid                 output register holds data
//     out_data   [WIDTH-1:0]    registered data
//     out_src    [SEL_W-1:0]    channel that supplied out_data
//     out_ready                 consumer accepts out_data
// -----------------------------------------------------------------------------
module arb_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_src;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load_en;
  logic [SEL_W-1:0]  w_rr_grant;
  logic              w_rr_any;
  logic [SEL_W-1:0]  w_grant;
  logic [NUM_IN-1:0] w_in_ready;
  logic              w_transfer;
  logic [WIDTH-1:0]  w_sel_data;

  // The register may take a new word when it is empty or being drained this
  // cycle, which gives full throughput with out_ready held high.
  assign w_load_en = !r_out_valid || out_ready;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_rr_arbiter (
    .i_valid     (in_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_rr_grant),
    .o_any_valid (w_rr_any)
  );

  // Grant and in_ready decode. An out-of-range sel in FIXED mode leaves every
  // in_ready bit low, so nothing is accepted.
  always_comb begin
    w_in_ready = '0;
    w_grant    = '0;
    if (mode == MODE_FIXED) begin
      w_grant = sel;
      if (int'(sel) < NUM_IN) begin
        w_in_ready[sel] = w_load_en;
      end
    end else begin
      w_grant                = w_rr_grant;
      w_in_ready[w_rr_grant] = w_load_en && w_rr_any;
    end
  end

  assign in_ready   = w_in_ready;
  assign w_transfer = |(in_valid & w_in_ready);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order or block count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_transfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_src   <= w_grant;
        if (mode == MODE_RR) begin
          r_ptr <= (int'(w_grant) == NUM_IN - 1) ? '0 : w_grant + SEL_W'(1);
        end
      end else if (out_ready) begin
        // Drained with nothing to replace it; data and source hold.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux
//   Directed bench for arb_mux. A 4-input instance covers fixed select,
//   back-pressure, round-robin order, skip/wrap and asynchronous reset; a
//   3-input instance covers an out-of-range select.
// -----------------------------------------------------------------------------
module tb_arb_mux;
  import mux_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  // 4-input instance
  logic              mode;
  logic [1:0]        sel;
  logic [3:0]        in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]        in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_src;
  logic              out_ready;

  // 3-input instance
  logic              mode3;
  logic [1:0]        sel3;
  logic [2:0]        in_valid3;
  logic [3*WIDTH-1:0] in_data3;
  logic [2:0]        in_ready3;
  logic              out_valid3;
  logic [WIDTH-1:0]  out_data3;
  logic [1:0]        out_src3;
  logic              out_ready3;

  int n_vec  = 0;
  int n_miss = 0;

  arb_mux #(.WIDTH(WIDTH), .NUM_IN(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(WIDTH), .NUM_IN(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    int         seq13 [4];

    rst_n      = 1'b0;
    mode       = MODE_FIXED;
    sel        = 2'd0;
    in_valid   = 4'b0000;
    in_data    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    out_ready  = 1'b0;
    mode3      = MODE_FIXED;
    sel3       = 2'd3;
    in_valid3  = 3'b000;
    in_data3   = {32'hC2, 32'hC1, 32'hC0};
    out_ready3 = 1'b1;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---- invalid select on the 3-input instance, then a legal one ----
    in_valid3 = 3'b111;
    #1;
    check("inv_sel_ready", 32'(in_ready3), 32'd0);
    tick();
    check("inv_sel_valid1", 32'(out_valid3), 32'd0);
    tick();
    check("inv_sel_valid2", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    check("n3_sel2_ready", 32'(in_ready3), 32'b100);
    tick();
    check("n3_sel2_data", out_data3, 32'hC2);
    check("n3_sel2_src",  32'(out_src3), 32'd2);

    // ---- FIXED select: sel = 2, all valid ----
    mode      = MODE_FIXED;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fixed_ready", 32'(in_ready), 32'b0100);
      tick();
      check("fixed_valid", 32'(out_valid), 32'd1);
      check("fixed_data",  out_data, 32'hA2);
      check("fixed_src",   32'(out_src), 32'd2);
    end

    // ---- back-pressure: stall 3 cycles, change sel mid-stall ----
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) sel = 2'd1;
      #1;
      check("stall_ready", 32'(in_ready), 32'd0);
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data",  out_data, 32'hA2);
      check("stall_src",   32'(out_src), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 32'(in_ready), 32'b0010);
    tick();
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_data",  out_data, 32'hA1);
    check("release_src",   32'(out_src), 32'd1);

    // ---- RR fairness: all valid, ptr still 0 (FIXED never moves it) ----
    mode = MODE_RR;
    for (int k = 0; k < 8; k++) begin
      exp_g = 2'(k % 4);
      #1;
      check("rr_ready", 32'(in_ready), 32'(4'b0001 << exp_g));
      tick();
      check("rr_src",  32'(out_src), 32'(exp_g));
      check("rr_data", out_data, 32'hA0 + 32'(exp_g));
    end

    // ---- RR skip: only 1 and 3 valid, ptr = 0 after the grant to 3 ----
    seq13    = '{1, 3, 1, 3};
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("skip_ready", 32'(in_ready), 32'(4'b0001 << seq13[k]));
      tick();
      check("skip_src", 32'(out_src), 32'(seq13[k]));
    end

    // ---- nothing valid: output drains, data/src hold ----
    in_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(in_ready), 32'd0);
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data",  out_data, 32'hA3);
    check("idle_src",   32'(out_src), 32'd3);

    // ---- wrap: grant 2 moves ptr to 3, then only channel 0 requests ----
    in_valid = 4'b0100;
    tick();
    check("wrap_pre_src", 32'(out_src), 32'd2);
    in_valid = 4'b0001;
    #1;
    check("wrap_ready", 32'(in_ready), 32'b0001);
    tick();
    check("wrap_src",  32'(out_src), 32'd0);
    check("wrap_data", out_data, 32'hA0);

    // ---- asynchronous reset mid-stream (ptr is 1 before reset) ----
    in_valid = 4'b1111;
    check("prerst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  out_data, 32'd0);
    check("arst_src",   32'(out_src), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("postrst_ready", 32'(in_ready), 32'b0001);
    tick();
    check("postrst_src",  32'(out_src), 32'd0);
    check("postrst_data", out_data, 32'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
